// File: rtl/col_readout_arbiter.sv
// ---------------------------------------------------------------------------
// col_readout_arbiter
//
// Round-robin arbiter that drains NUM_COL column FIFOs into a single
// valid/ready output stream. Each delivered word is tagged with the index of
// the column it came from.
//
// Optional feature: define COL_MASK_EN to add the col_enable port. Without it,
// every column takes part in arbitration.
//
// Ports
//   clk_40MHz       in   clock
//   rst             in   synchronous active-high reset
//   col_fifo_empty  in   [NUM_COL]     per-column FIFO empty flag
//   col_fifo_dout   in   [NUM_COL*28]  per-column read data. Column k is at
//                                      bits [28k+27:28k] and is valid one
//                                      cycle after its read strobe.
//   col_fifo_rd     out  [NUM_COL]     one-hot read strobe
//   col_enable      in   [NUM_COL]     participation mask (COL_MASK_EN only)
//   out_data        out  [IDX_W+28]    {column index, 28-bit column word}
//   out_valid       out  out_data valid
//   out_ready       in   downstream accepts out_data
//   busy            out  transaction in progress
//   word_cnt        out  [16]          number of words delivered (wraps)
//
// Handshake: out_valid is held high, and out_data is held stable, until the
// first cycle on which out_valid & out_ready are both high. That cycle is the
// transfer. out_valid falls on the next cycle. out_ready has no effect while
// out_valid is low.
// ---------------------------------------------------------------------------
module col_readout_arbiter #(
  parameter int NUM_COL = 8,
  parameter int IDX_W   = 3
) (
  input  logic                   clk_40MHz,
  input  logic                   rst,
  input  logic [NUM_COL-1:0]     col_fifo_empty,
  input  logic [NUM_COL*28-1:0]  col_fifo_dout,
  output logic [NUM_COL-1:0]     col_fifo_rd,
`ifdef COL_MASK_EN
  input  logic [NUM_COL-1:0]     col_enable,
`endif
  output logic [IDX_W+27:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [15:0]            word_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_elig;
  logic [NUM_COL-1:0] eligible;
  logic [27:0]        sel_word;

`ifdef COL_MASK_EN
  assign eligible = ~col_fifo_empty & col_enable;
`else
  assign eligible = ~col_fifo_empty;
`endif

  // Rotating priority search. It starts at last_grant+1. The index wraps
  // naturally because NUM_COL is a power of two. On the final iteration the
  // offset truncates to 0, so last_grant itself is considered last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    any_elig  = 1'b0;
    grant_idx = last_grant;
    cand      = '0;
    for (int i = 1; i <= NUM_COL; i++) begin
      cand = last_grant + IDX_W'(i);
      if (!any_elig && eligible[cand]) begin
        any_elig  = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Read data of the column granted in the previous (IDLE) cycle.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < NUM_COL; k++) begin
      if (last_grant == IDX_W'(k)) begin
        sel_word = col_fifo_dout[28*k +: 28];
      end
    end
  end

  // State register.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_elig) state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs. The strobe is gated by rst so that no read is issued during
  // the reset cycle, even when the state before reset was IDLE.
  always_comb begin
    col_fifo_rd = '0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        if (any_elig && !rst) col_fifo_rd[grant_idx] = 1'b1;
      end
      RD_WAIT, HOLD: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  // Datapath registers: grant pointer, output word and delivery counter.
  always_ff @(posedge clk_40MHz) begin
    if (rst) begin
      last_grant <= IDX_W'(NUM_COL - 1);
      out_data   <= '0;
      out_valid  <= 1'b0;
      word_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_elig) last_grant <= grant_idx;
        end
        RD_WAIT: begin
          // Capture unconditionally. Empty or enable changes after the grant
          // must not drop the word that was already read.
          out_data  <= {last_grant, sel_word};
          out_valid <= 1'b1;
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            word_cnt  <= word_cnt + 16'd1;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_col_readout_arbiter.sv
// ---------------------------------------------------------------------------
// tb_col_readout_arbiter
//
// Directed bench for col_readout_arbiter (NUM_COL=8). It contains:
//   - a clock/reset block
//   - driver tasks
//   - a scoreboard queue of expected output words
//   - a protocol monitor
//   - a final summary line
// ---------------------------------------------------------------------------
module tb_col_readout_arbiter;

  localparam int NUM_COL = 8;
  localparam int IDX_W   = 3;
  localparam int OUT_W   = IDX_W + 28;

  logic                  clk_40MHz;
  logic                  rst;
  logic [NUM_COL-1:0]    col_fifo_empty;
  logic [NUM_COL*28-1:0] col_fifo_dout;
  logic [NUM_COL-1:0]    col_fifo_rd;
`ifdef COL_MASK_EN
  logic [NUM_COL-1:0]    col_enable;
`endif
  logic [OUT_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic [15:0]           word_cnt;

  logic [27:0]      data_mem [NUM_COL];
  logic [OUT_W-1:0] exp_q [$];
  logic [15:0]      exp_cnt;
  int               n_cmp;
  int               n_bad;
  bit               mon_en;

  col_readout_arbiter #(.NUM_COL(NUM_COL), .IDX_W(IDX_W)) dut (
    .clk_40MHz      (clk_40MHz),
    .rst            (rst),
    .col_fifo_empty (col_fifo_empty),
    .col_fifo_dout  (col_fifo_dout),
    .col_fifo_rd    (col_fifo_rd),
`ifdef COL_MASK_EN
    .col_enable     (col_enable),
`endif
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .word_cnt       (word_cnt)
  );

  // Clock/reset block.
  initial clk_40MHz = 1'b0;
  always #10 clk_40MHz = ~clk_40MHz;

  always_comb begin
    col_fifo_dout = '0;
    for (int k = 0; k < NUM_COL; k++) col_fifo_dout[28*k +: 28] = data_mem[k];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_40MHz);
    #1;
  endtask

  function automatic logic [27:0] col_word(input int k);
    return 28'h5000000 + 28'(k) * 28'h0010101;
  endfunction

  // Protocol monitor:
  //   - at most one strobe bit is high
  //   - no strobe while busy or while in reset
  always @(negedge clk_40MHz) begin
    if (mon_en) begin
      check("rd_onehot", 64'($onehot0(col_fifo_rd)), 64'd1);
      if (busy || rst) check("rd_when_not_idle", 64'(col_fifo_rd), 64'd0);
    end
  end

  // Run one transaction. The expected grant is exp_col, with payload exp_word.
  // hold       = cycles spent in HOLD with out_ready low before acceptance.
  // back2back  = the strobe must appear without any idle gap.
  task automatic run_word(input int exp_col, input logic [27:0] exp_word,
                          input int hold, input bit back2back);
    int waited;
    logic [NUM_COL-1:0] exp_rd;
    logic [OUT_W-1:0]   exp_out;
    logic [OUT_W-1:0]   held;
    waited = 0;
    exp_rd = '0;
    exp_rd[exp_col] = 1'b1;
    exp_q.push_back({IDX_W'(exp_col), exp_word});
    out_ready = (hold == 0);
    #1;
    while (col_fifo_rd == '0 && waited < 20) begin
      step();
      waited++;
    end
    check("grant_timeout", 64'(waited < 20), 64'd1);
    if (back2back) check("strobe_gap", 64'(waited), 64'd0);
    check("rd_strobe", 64'(col_fifo_rd), 64'(exp_rd));
    check("busy_idle", 64'(busy), 64'd0);
    step();  // RD_WAIT
    check("rd_in_wait", 64'(col_fifo_rd), 64'd0);
    check("busy_wait", 64'(busy), 64'd1);
    check("valid_wait", 64'(out_valid), 64'd0);
    step();  // HOLD
    exp_out = exp_q.pop_front();
    check("valid_hold", 64'(out_valid), 64'd1);
    check("out_data", 64'(out_data), 64'(exp_out));
    held = out_data;
    for (int h = 0; h < hold; h++) begin
      step();
      check("valid_stall", 64'(out_valid), 64'd1);
      check("data_stall", 64'(out_data), 64'(held));
      check("rd_stall", 64'(col_fifo_rd), 64'd0);
    end
    out_ready = 1'b1;
    step();  // handshake edge
    exp_cnt = exp_cnt + 16'd1;
    check("valid_after_hs", 64'(out_valid), 64'd0);
    check("word_cnt", 64'(word_cnt), 64'(exp_cnt));
    check("busy_after_hs", 64'(busy), 64'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    mon_en = 1'b0;
    exp_cnt = '0;
    rst = 1'b1;
    out_ready = 1'b0;
    col_fifo_empty = '0;  // all columns non-empty during reset: no strobe allowed
`ifdef COL_MASK_EN
    col_enable = '1;
`endif
    for (int k = 0; k < NUM_COL; k++) data_mem[k] = col_word(k);
    step();
    mon_en = 1'b1;
    step();
    step();

    // Reset state.
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cnt", 64'(word_cnt), 64'd0);
    check("rst_rd", 64'(col_fifo_rd), 64'd0);

    // Only column 3 holds data.
    col_fifo_empty = 8'hF7;
    data_mem[3] = 28'h0ABCDEF;
    rst = 1'b0;
    run_word(3, 28'h0ABCDEF, 0, 1'b0);
    col_fifo_empty = 8'hFF;
    step();
    check("idle_rd", 64'(col_fifo_rd), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    data_mem[3] = col_word(3);

    // All columns full: round robin from 0 with one strobe every 3 cycles.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
    col_fifo_empty = 8'h00;
    for (int n = 0; n < 9; n++) run_word(n % NUM_COL, col_word(n % NUM_COL), 0, n > 0);

    // Downstream stall in HOLD for 10 cycles.
    run_word(1, col_word(1), 10, 1'b1);

    // Counter wrap: preload near the top, then deliver two more words.
    force dut.word_cnt = 16'hFFFE;
    #1;
    release dut.word_cnt;
    exp_cnt = 16'hFFFE;
    run_word(2, col_word(2), 0, 1'b0);
    run_word(3, col_word(3), 0, 1'b1);
    check("cnt_wrapped", 64'(word_cnt), 64'd0);

    // Reset while a word is held: it is dropped, and arbitration restarts at 0.
    out_ready = 1'b0;
    step();
    step();
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    step();
    check("rst_hold_valid", 64'(out_valid), 64'd0);
    check("rst_hold_cnt", 64'(word_cnt), 64'd0);
    check("rst_hold_rd", 64'(col_fifo_rd), 64'd0);
    rst = 1'b0;
    exp_cnt = '0;
    run_word(0, col_word(0), 0, 1'b0);

`ifdef COL_MASK_EN
    // Column 0 is masked off: only column 1 is ever granted.
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = '0;
    col_enable = 8'hFE;
    col_fifo_empty = 8'hFC;
    run_word(1, col_word(1), 0, 1'b0);
    run_word(1, col_word(1), 0, 1'b1);
    col_enable = 8'hFF;
`endif

    col_fifo_empty = 8'hFF;
    step();
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/col_readout_arbiter.md
COL_READOUT_ARBITER -- requirements
Module: col_readout_arbiter

Interface
REQ-001 The block SHALL have one parameter: NUM_COL, default 8, number of column FIFOs shared (power of 2, 2..16).
REQ-002 The block SHALL have one parameter: IDX_W, default 3, column index width, log2(NUM_COL).
REQ-003 The block SHALL have one clock and one reset: clock clk_40MHz; reset rst, synchronous, active-high.
REQ-004 Ports SHALL be:
- clk_40MHz  in  1  clock
- rst  in  1  synchronous active-high reset
- col_fifo_empty  in  NUM_COL  per-column FIFO empty flag
- col_fifo_dout  in  NUM_COL*28  per-column FIFO read data, column k at bits [28k+27:28k]; valid one cycle after its read strobe
- col_fifo_rd  out  NUM_COL  one-hot read strobe
- col_enable  in  NUM_COL  column participation mask; present only with COL_MASK_EN
- out_data  out  IDX_W+28  {column index, 28-bit column word}
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data
- busy  out  1  transaction in progress
- word_cnt  out  16  count of words delivered

Function
REQ-005 Column k SHALL be eligible when col_fifo_empty[k]=0 and, with COL_MASK_EN defined, col_enable[k]=1.
REQ-006 The FSM SHALL have three states: IDLE, RD_WAIT, HOLD.
REQ-007 IDLE: if any column is eligible, the FSM SHALL grant the first eligible column searching from (last_grant+1) mod NUM_COL upward with wrap, pulse col_fifo_rd for exactly that column for one cycle, store it as last_grant, and go to RD_WAIT; otherwise it SHALL stay in IDLE with col_fifo_rd=0.
REQ-008 RD_WAIT: the FSM SHALL capture {grant index, col_fifo_dout of granted column} into out_data, set out_valid=1, and go to HOLD; col_fifo_rd SHALL be 0.
REQ-009 HOLD: out_data and out_valid SHALL remain stable until out_valid & out_ready; on that cycle out_valid SHALL fall next cycle, word_cnt SHALL increment, and the FSM SHALL return to IDLE.
REQ-010 Minimum latency from read strobe to out_valid SHALL be 2 cycles; maximum throughput SHALL be one word per 3 cycles.
REQ-011 At most one col_fifo_rd bit SHALL be high in any cycle; col_fifo_rd SHALL never be high outside IDLE.
REQ-012 busy SHALL be 1 in RD_WAIT and HOLD, 0 in IDLE.
REQ-013 word_cnt SHALL wrap from 16'hFFFF to 16'h0000.
REQ-014 A column's empty flag or enable bit changing after its grant SHALL NOT abort the transaction; the captured word SHALL still be delivered.
REQ-015 out_ready high while out_valid=0 SHALL have no effect.

Reset
REQ-016 With rst=1 at a clk_40MHz edge, the block SHALL set state=IDLE, out_valid=0, out_data=0, col_fifo_rd=0, busy=0, word_cnt=0, and last_grant=NUM_COL-1, so column 0 is searched first.
REQ-017 A reset during RD_WAIT or HOLD SHALL discard the in-flight word without delivery; no read strobe SHALL issue in the reset cycle.

Configuration
REQ-018 Macro COL_MASK_EN: when defined, the col_enable port SHALL exist and gate eligibility per REQ-005; when undefined, the port SHALL be absent and all columns SHALL be treated as enabled.

Verification
REQ-019 After reset, only column 3 is non-empty with dout=28'h0ABCDEF and out_ready=1 -> col_fifo_rd=8'h08 for 1 cycle, out_data={3'd3,28'h0ABCDEF} 2 cycles later, word_cnt=1.
REQ-020 All 8 columns remain non-empty, out_ready=1 -> grant order 0,1,...,7,0, one col_fifo_rd pulse every 3 cycles, never two bits set.
REQ-021 out_ready is held 0 for 10 cycles in HOLD -> out_data and out_valid are stable, no col_fifo_rd pulses; one handshake when out_ready rises.
REQ-022 word_cnt is preloaded through 65535 handshakes -> next handshake gives word_cnt=0.
REQ-023 rst is asserted in HOLD -> next cycle out_valid=0, word_cnt=0, and the next grant goes to column 0.
REQ-024 With COL_MASK_EN, col_enable=8'hFE and columns 0 and 1 non-empty -> only column 1 is granted and column 0 is never read.
